prog_loader: RTL and testbench

Serial program loader for the 8-bit CPU's 256-byte instruction memory. Receives a framed program image over a UART line (8N1), writes each byte through a memory write port at incrementing addresses, verifies an 8-bit checksum, and holds the CPU while a load is in progress. It is the writer side of program memory, which the CPU only reads.

---
 rtl/prog_loader_if.sv | 23 ++
 rtl/prog_loader.sv | 181 ++++++++++++++++++
 tb/tb_prog_loader.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Program-memory write port and loader status, plus the serial line feeding the loader.
// master = the loader (drives memory/status), slave = memory/CPU side (drives rx).
interface prog_loader_if;
    logic       rx;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;

    // wr_en is a single-cycle strobe with no ready: the 10-bit-time byte spacing
    // guarantees memory can always accept, so there is no backpressure path.
    modport master (
        input  rx,
        output wr_en, wr_addr, wr_data, cpu_hold, load_done, load_err
    );

    modport slave (
        output rx,
        input  wr_en, wr_addr, wr_data, cpu_hold, load_done, load_err
    );
endinterface

// File: rtl/prog_loader.sv
// Serial program loader: 8N1 UART receiver feeding a frame parser that writes
// HEADER/LEN/data/CSUM frames into program memory and holds the CPU while loading.
module prog_loader #(
    parameter int         CLKS_PER_BIT = 16,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    prog_loader_if.master     bus,
    output logic [1:0]        ld_state_o,
    output logic [2:0]        rx_state_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_WAIT  = 3'd4
    } rx_state_e;

    typedef enum logic [1:0] {
        L_IDLE = 2'd0,
        L_LEN  = 2'd1,
        L_DATA = 2'd2,
        L_CSUM = 2'd3
    } ld_state_e;

    logic          rx_meta_q, rx_sync_q;
    rx_state_e     rx_state_q;
    logic [CW-1:0] bit_cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;

    logic          stop_tick, byte_valid, frame_err;

    ld_state_e     ld_state_q;
    logic [8:0]    remain_q;
    logic [7:0]    sum_q;
    logic          wr_en_q;
    logic [7:0]    wr_addr_q, wr_data_q;
    logic          hold_q, done_q, err_q;

    // Receiver: counter restarts at every sample point so all samples land mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
        end else begin
            rx_meta_q <= bus.rx;
            rx_sync_q <= rx_meta_q;
            case (rx_state_q)
                RX_IDLE: begin
                    if (!rx_sync_q) begin
                        rx_state_q <= RX_START;
                        bit_cnt_q  <= '0;
                    end
                end
                RX_START: begin
                    if (bit_cnt_q == HALF_M1) begin
                        bit_cnt_q  <= '0;
                        bit_idx_q  <= '0;
                        rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (bit_cnt_q == BIT_M1) begin
                        bit_cnt_q <= '0;
                        shift_q   <= {rx_sync_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (bit_cnt_q == BIT_M1) begin
                        bit_cnt_q  <= '0;
                        rx_state_q <= rx_sync_q ? RX_IDLE : RX_WAIT;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                    end
                end
                RX_WAIT: begin
                    if (rx_sync_q) begin
                        rx_state_q <= RX_IDLE;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign stop_tick  = (rx_state_q == RX_STOP) && (bit_cnt_q == BIT_M1);
    assign byte_valid = stop_tick && rx_sync_q;
    assign frame_err  = stop_tick && !rx_sync_q;

    // Frame parser: acts on the edge after byte_valid/frame_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_state_q <= L_IDLE;
            remain_q   <= '0;
            sum_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (wr_en_q) begin
                wr_addr_q <= wr_addr_q + 8'd1;
            end
            if (frame_err) begin
                if (ld_state_q != L_IDLE) begin
                    err_q      <= 1'b1;
                    ld_state_q <= L_IDLE;
                end
            end else if (byte_valid) begin
                case (ld_state_q)
                    L_IDLE: begin
                        if (shift_q == HEADER) begin
                            ld_state_q <= L_LEN;
                            hold_q     <= 1'b1;
                            done_q     <= 1'b0;
                            err_q      <= 1'b0;
                            wr_addr_q  <= '0;
                            sum_q      <= '0;
                        end
                    end
                    L_LEN: begin
                        remain_q   <= (shift_q == 8'd0) ? 9'd256 : {1'b0, shift_q};
                        ld_state_q <= L_DATA;
                    end
                    L_DATA: begin
                        wr_data_q <= shift_q;
                        wr_en_q   <= 1'b1;
                        sum_q     <= sum_q + shift_q;
                        remain_q  <= remain_q - 9'd1;
                        if (remain_q == 9'd1) begin
                            ld_state_q <= L_CSUM;
                        end
                    end
                    L_CSUM: begin
                        if (shift_q == sum_q) begin
                            done_q <= 1'b1;
                            hold_q <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                        ld_state_q <= L_IDLE;
                    end
                    default: ld_state_q <= L_IDLE;
                endcase
            end
        end
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.cpu_hold  = hold_q;
    assign bus.load_done = done_q;
    assign bus.load_err  = err_q;
    assign ld_state_o    = ld_state_q;
    assign rx_state_o    = rx_state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: UART byte driver, frame-level reference model,
// per-cycle compare of writes and status flags, plus literal spot checks.
module tb_prog_loader;

    localparam int         CPB    = 4;
    localparam logic [7:0] HEADER = 8'hA5;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prog_loader_if bus ();
    logic [1:0] ld_state;
    logic [2:0] rx_state;

    prog_loader #(.CLKS_PER_BIT(CPB), .HEADER(HEADER)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.master),
        .ld_state_o (ld_state),
        .rx_state_o (rx_state)
    );

    // ---------------- reference model ----------------
    int          checks   = 0;
    int          errors   = 0;
    int          n_writes = 0;
    bit          busy     = 1'b1;
    logic [15:0] exp_q[$];

    int   m_phase;   // 0 waiting header, 1 length, 2 data, 3 checksum
    int   m_left, m_sum, m_addr;
    logic m_hold, m_done, m_err;

    function automatic void model_reset();
        m_phase = 0; m_left = 0; m_sum = 0; m_addr = 0;
        m_hold = 1'b0; m_done = 1'b0; m_err = 1'b0;
    endfunction

    function automatic void model_byte(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) begin
            if (m_phase != 0) begin
                m_err   = 1'b1;
                m_phase = 0;
            end
            return;
        end
        case (m_phase)
            0: if (b == HEADER) begin
                m_phase = 1; m_hold = 1'b1; m_done = 1'b0; m_err = 1'b0;
                m_addr = 0; m_sum = 0;
            end
            1: begin
                m_left  = (b == 8'd0) ? 256 : int'(b);
                m_phase = 2;
            end
            2: begin
                exp_q.push_back({8'(m_addr), b});
                m_addr = (m_addr + 1) % 256;
                m_sum  = (m_sum + int'(b)) % 256;
                m_left = m_left - 1;
                if (m_left == 0) m_phase = 3;
            end
            default: begin
                if (int'(b) == m_sum) begin
                    m_done = 1'b1; m_hold = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
                m_phase = 0;
            end
        endcase
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            logic [15:0] e;
            checks++;
            n_writes++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h, required no write", bus.wr_addr, bus.wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({bus.wr_addr, bus.wr_data} !== e) begin
                    errors++;
                    $display("FAIL write: got addr %0h data %0h, required addr %0h data %0h",
                             bus.wr_addr, bus.wr_data, e[15:8], e[7:0]);
                end
            end
        end
        if (!busy) begin
            checks++;
            if ({bus.cpu_hold, bus.load_done, bus.load_err, bus.wr_en} !== {m_hold, m_done, m_err, 1'b0}) begin
                errors++;
                $display("FAIL flags: got hold/done/err/wr_en %b%b%b%b, required %b%b%b0",
                         bus.cpu_hold, bus.load_done, bus.load_err, bus.wr_en, m_hold, m_done, m_err);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        busy   = 1'b1;
        bus.rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            tick(CPB);
        end
        model_byte(b, stop_ok);
        bus.rx = stop_ok;
        tick(CPB);
        bus.rx = 1'b1;
        tick(8);
        busy = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i], 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w0;
        bus.rx = 1'b1;
        model_reset();
        tick(4);
        #1;
        check("reset_outputs", {bus.wr_en, bus.wr_addr, bus.wr_data, bus.cpu_hold, bus.load_done, bus.load_err},
              32'h0);
        rst_n = 1'b1;
        tick(2);
        busy = 1'b0;

        // 1: idle line, nothing may change
        tick(100);
        check("idle_no_writes", n_writes, 0);

        // 2: good frame
        send_bytes('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66});
        #1;
        check("good_hold", bus.cpu_hold, 0);
        check("good_done", bus.load_done, 1);
        check("good_err", bus.load_err, 0);
        check("good_writes", n_writes, 3);

        // 3: bad checksum then recovery
        send_bytes('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31});
        #1;
        check("badsum_err", bus.load_err, 1);
        check("badsum_hold", bus.cpu_hold, 1);
        check("badsum_done", bus.load_done, 0);
        send_bytes('{8'hA5, 8'h01, 8'h07, 8'h07});
        #1;
        check("recover_done_err_hold", {bus.load_done, bus.load_err, bus.cpu_hold}, 32'b100);

        // 4: full 256-byte frame, wr_addr == wr_data
        w0 = n_writes;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 256; i++) send_byte(8'(i), 1'b1);
        send_byte(8'h80, 1'b1);
        #1;
        check("full_count", n_writes - w0, 256);
        check("full_final_addr", bus.wr_addr, 0);
        check("full_done", bus.load_done, 1);

        // 5: framing error mid-frame, then a stray byte in idle
        w0 = n_writes;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h55, 1'b0);
        #1;
        check("frerr_err", bus.load_err, 1);
        check("frerr_hold", bus.cpu_hold, 1);
        check("frerr_state_idle", ld_state, 0);
        send_byte(8'h33, 1'b1);
        #1;
        check("frerr_no_writes", n_writes - w0, 0);

        // 6a: one-cycle glitch is a false start
        w0 = n_writes;
        bus.rx = 1'b0;
        tick(1);
        bus.rx = 1'b1;
        tick(3 * CPB);
        #1;
        check("glitch_rx_idle", rx_state, 0);
        check("glitch_err_kept", bus.load_err, 1);

        // 6b: reset after second data byte of a 5-byte frame
        send_bytes('{8'hA5, 8'h05, 8'h01, 8'h02});
        busy = 1'b1;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_outputs", {bus.wr_en, bus.wr_addr, bus.wr_data, bus.cpu_hold, bus.load_done, bus.load_err},
              32'h0);
        tick(3);
        #1 rst_n = 1'b1;
        tick(4);
        busy = 1'b0;
        send_bytes('{8'h03, 8'h04, 8'h05});
        tick(10);
        check("midreset_writes", n_writes - w0, 2);
        check("exp_queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
